// File: rtl/piece_placer_if.sv
// Handshake and row-RAM bundle for piece_placer.
// full_rows exists only when PLACER_FULL_ROWS_EN is defined.
interface piece_placer_if #(
  parameter int unsigned ROW_W = 10
);
  logic             start;
  logic             commit;
  logic [15:0]      matrix;
  logic [5:0]       pos_x;
  logic [5:0]       pos_y;
  logic             busy;
  logic             done;
  logic             collide;
  logic             rd_en;
  logic [4:0]       rd_addr;
  logic [ROW_W-1:0] rd_data;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [ROW_W-1:0] wr_data;
`ifdef PLACER_FULL_ROWS_EN
  logic [3:0]       full_rows;

  modport master (
    output start, commit, matrix, pos_x, pos_y, rd_data,
    input  busy, done, collide, rd_en, rd_addr, wr_en, wr_addr, wr_data, full_rows
  );
  modport slave (
    input  start, commit, matrix, pos_x, pos_y, rd_data,
    output busy, done, collide, rd_en, rd_addr, wr_en, wr_addr, wr_data, full_rows
  );
`else
  modport master (
    output start, commit, matrix, pos_x, pos_y, rd_data,
    input  busy, done, collide, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  start, commit, matrix, pos_x, pos_y, rd_data,
    output busy, done, collide, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/piece_placer.sv
// Walks a 4x4 piece against the playfield row RAM, reports collision and
// optionally merges the piece into the board. Fixed latency: 8 check cycles,
// plus 4 write cycles on a clear commit.
// Optional feature macro: PLACER_FULL_ROWS_EN (reports rows filled by a commit).
module piece_placer #(
  parameter int unsigned ROW_W = 10,
  parameter int unsigned ROWS  = 20
) (
  input logic            clk,
  input logic            reset,
  piece_placer_if.slave  if_placer
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [1:0]       r_row;
  logic             r_commit;
  logic [15:0]      r_mat;
  logic [5:0]       r_x;
  logic [5:0]       r_y;
  logic             r_collide;
  logic [3:0]       r_rd;
  logic [ROW_W-1:0] r_buf [4];
`ifdef PLACER_FULL_ROWS_EN
  logic [3:0]       r_full;
`endif

  logic [3:0]       w_nib;
  logic [3:0]       w_rev;
  logic [5:0]       w_ry;
  logic [5:0]       w_sh;
  logic [ROW_W+7:0] w_ext;
  logic [ROW_W-1:0] w_mask;
  logic             w_wall;
  logic             w_above;
  logic             w_floor;
  logic             w_nonempty;
  logic             w_read;
  logic             w_hit;
  logic             w_collide_d;
  logic             w_wr;

  // Geometry of the current row: board row, shifted cell mask, wall/floor hits
  always_comb begin
    unique case (r_row)
      2'd0:    w_nib = r_mat[15:12];
      2'd1:    w_nib = r_mat[11:8];
      2'd2:    w_nib = r_mat[7:4];
      default: w_nib = r_mat[3:0];
    endcase
    // Nibble MSB is column offset 0, board bit j is column j
    w_rev      = {w_nib[0], w_nib[1], w_nib[2], w_nib[3]};
    w_ry       = r_y + {4'd0, r_row};
    // Bias by 3 so x = -3 maps to a non-negative shift; bits landing below
    // bit 3 or above the board width are off the left/right wall.
    w_sh       = r_x + 6'd3;
    w_ext      = {{(ROW_W + 4){1'b0}}, w_rev} << w_sh;
    w_mask     = w_ext[ROW_W+2:3];
    w_wall     = (|w_ext[2:0]) | (|w_ext[ROW_W+7:ROW_W+3]);
    w_above    = w_ry[5];
    w_floor    = !w_above && (w_ry >= 6'(ROWS));
    w_nonempty = |w_nib;
    w_read     = w_nonempty && !w_above && !w_floor;
    w_hit      = w_nonempty && !w_above &&
                 (w_floor || w_wall || (w_read && |(w_mask & if_placer.rd_data)));
    w_collide_d = r_collide | w_hit;
    w_wr       = (r_state == S_WRITE) && r_rd[r_row];
  end

  // Sequencer: latch request, walk ADDR/CMP per row, optional WRITE pass
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_row     <= 2'd0;
      r_commit  <= 1'b0;
      r_mat     <= 16'd0;
      r_x       <= 6'd0;
      r_y       <= 6'd0;
      r_collide <= 1'b0;
      r_rd      <= 4'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (if_placer.start) begin
            r_state   <= S_ADDR;
            r_row     <= 2'd0;
            r_commit  <= if_placer.commit;
            r_mat     <= if_placer.matrix;
            r_x       <= if_placer.pos_x;
            r_y       <= if_placer.pos_y;
            r_collide <= 1'b0;
            r_rd      <= 4'd0;
          end
        end
        S_ADDR: r_state <= S_CMP;
        S_CMP: begin
          r_collide <= w_collide_d;
          if (w_read) begin
            r_buf[r_row] <= if_placer.rd_data;
            r_rd[r_row]  <= 1'b1;
          end
          if (r_row == 2'd3) begin
            r_row   <= 2'd0;
            r_state <= (r_commit && !w_collide_d) ? S_WRITE : S_DONE;
          end else begin
            r_row   <= r_row + 2'd1;
            r_state <= S_ADDR;
          end
        end
        S_WRITE: begin
          if (r_row == 2'd3) r_state <= S_DONE;
          r_row <= r_row + 2'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PLACER_FULL_ROWS_EN
  // Record rows that become all ones during the write pass
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 4'd0;
    end else if (r_state == S_IDLE && if_placer.start) begin
      r_full <= 4'd0;
    end else if (w_wr && (&(r_buf[r_row] | w_mask))) begin
      r_full[r_row] <= 1'b1;
    end
  end
`endif

  // Output decode; addresses and data are zero whenever their strobe is low
  always_comb begin
    if_placer.busy    = (r_state != S_IDLE);
    if_placer.done    = (r_state == S_DONE);
    if_placer.collide = r_collide;
    if_placer.rd_en   = (r_state == S_ADDR) && w_read;
    if_placer.rd_addr = if_placer.rd_en ? w_ry[4:0] : 5'd0;
    if_placer.wr_en   = w_wr;
    if_placer.wr_addr = w_wr ? w_ry[4:0] : 5'd0;
    if_placer.wr_data = w_wr ? (r_buf[r_row] | w_mask) : '0;
`ifdef PLACER_FULL_ROWS_EN
    if_placer.full_rows = (r_state == S_DONE || r_state == S_IDLE) ? r_full : 4'd0;
`endif
  end

endmodule

// File: tb/tb_piece_placer.sv
// Bench for piece_placer: directed scenarios, then randomized placements
// checked against a cell-level reference model of the board.
module tb_piece_placer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piece_placer_if #(.ROW_W(10)) bus ();

  piece_placer #(.ROW_W(10), .ROWS(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_placer (bus)
  );

  // Row RAM model: 1-cycle read latency, image preload port for the bench
  logic [9:0] ram [32];
  logic [9:0] img [32];
  logic       ld = 1'b0;
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 32; i++) ram[i] <= img[i];
      bus.rd_data <= 10'd0;
    end else begin
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
      if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_board();
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 10'd0;
  endtask

  // Reference model results
  logic        e_coll;
  logic [31:0] e_rd;
  logic [31:0] e_wr;
  logic [3:0]  e_full;
  int          e_done;
  logic [9:0]  e_board [20];

  task automatic model(input logic cm, input logic [15:0] mat, input int x, input int y);
    logic [3:0] nib;
    int by, bx;
    for (int i = 0; i < 20; i++) e_board[i] = ram[i];
    e_coll = 1'b0; e_rd = 32'd0; e_full = 4'd0;
    for (int r = 0; r < 4; r++) begin
      by  = y + r;
      nib = 4'((mat >> (12 - 4 * r)) & 16'hF);
      if (nib != 4'd0 && by >= 0 && by < 20) e_rd |= 32'd1 << by;
      for (int c = 0; c < 4; c++) begin
        bx = x + c;
        if (mat[15 - 4 * r - c] && by >= 0) begin
          if (bx < 0 || bx >= 10 || by >= 20) e_coll = 1'b1;
          else if (e_board[by][bx]) e_coll = 1'b1;
        end
      end
    end
    if (cm && !e_coll) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (mat[15 - 4 * r - c] && y + r >= 0) e_board[y + r][x + c] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        by = y + r;
        if (by >= 0 && by < 20 && e_rd[by] && e_board[by] == 10'h3FF) e_full[r] = 1'b1;
      end
      e_wr   = e_rd;
      e_done = 13;
    end else begin
      e_wr   = 32'd0;
      e_done = 9;
    end
  endtask

  task automatic run_op(input string name, input logic cm, input logic [15:0] mat,
                        input int x, input int y, input bit hold);
    logic [31:0] obs_rd, obs_wr;
    logic        obs_coll;
    int          busy_cnt, done_cyc, diff;
`ifdef PLACER_FULL_ROWS_EN
    logic [3:0]  obs_full = 4'd0;
`endif
    model(cm, mat, x, y);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.commit = cm;
    bus.matrix = mat;
    bus.pos_x  = 6'(x);
    bus.pos_y  = 6'(y);
    @(posedge clk);
    obs_rd = 32'd0; obs_wr = 32'd0; obs_coll = 1'b0; busy_cnt = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        // Inputs after acceptance must be ignored; a held start must not restart
        bus.start  = hold;
        bus.commit = 1'($urandom);
        bus.matrix = 16'($urandom);
        bus.pos_x  = 6'($urandom);
        bus.pos_y  = 6'($urandom);
      end
      if (bus.busy)  busy_cnt++;
      if (bus.rd_en) obs_rd |= 32'd1 << bus.rd_addr;
      if (bus.wr_en) obs_wr |= 32'd1 << bus.wr_addr;
      if (bus.done) begin
        done_cyc = cyc;
        obs_coll = bus.collide;
`ifdef PLACER_FULL_ROWS_EN
        obs_full = bus.full_rows;
`endif
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({name, ".collide"}, 32'(obs_coll), 32'(e_coll));
    check({name, ".done_cycle"}, 32'(done_cyc), 32'(e_done));
    check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(e_done));
    check({name, ".read_rows"}, obs_rd, e_rd);
    check({name, ".write_rows"}, obs_wr, e_wr);
`ifdef PLACER_FULL_ROWS_EN
    check({name, ".full_rows"}, 32'(obs_full), 32'(e_full));
`endif
    @(negedge clk);
    check({name, ".idle_after"}, {29'd0, bus.busy, bus.done, bus.collide},
          {29'd0, 1'b0, 1'b0, e_coll});
    diff = 0;
    for (int i = 0; i < 20; i++) if (ram[i] !== e_board[i]) diff++;
    check({name, ".board_rows_differing"}, 32'(diff), 32'd0);
  endtask

  logic [15:0] shapes [8];
  logic [15:0] shp;
  int          dones;

  initial begin
    shapes[0] = 16'h0660; shapes[1] = 16'h4444; shapes[2] = 16'h0F00; shapes[3] = 16'h4640;
    shapes[4] = 16'h4460; shapes[5] = 16'h2260; shapes[6] = 16'h0C60; shapes[7] = 16'h000F;
    reset = 1'b1;
    bus.start = 1'b0; bus.commit = 1'b0; bus.matrix = 16'd0; bus.pos_x = 6'd0; bus.pos_y = 6'd0;
    clear_img();
    load_board();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {7'd0, bus.busy, bus.done, bus.collide, bus.rd_en, bus.wr_en,
                            bus.rd_addr, bus.wr_addr, bus.wr_data}, 32'd0);
`ifdef PLACER_FULL_ROWS_EN
    check("reset_full_rows", 32'(bus.full_rows), 32'd0);
`endif
    reset = 1'b0;

    // Directed scenarios
    clear_img(); load_board();
    run_op("sq_check", 1'b0, 16'h0660, 4, 0, 1'b0);
    run_op("sq_floor", 1'b1, 16'h0660, 4, 18, 1'b0);
    run_op("bar_x_m1", 1'b0, 16'h4444, -1, 0, 1'b1);
    run_op("bar_x_m2", 1'b0, 16'h4444, -2, 0, 1'b0);
    run_op("bar_right", 1'b0, 16'h4444, 8, 3, 1'b0);
    run_op("bar_x_m3", 1'b0, 16'h4444, -3, 3, 1'b0);
    clear_img(); img[5] = 10'h3FF; load_board();
    run_op("row5_full", 1'b1, 16'h0F00, 0, 4, 1'b0);
    clear_img(); load_board();
    run_op("row5_write", 1'b1, 16'h0F00, 0, 4, 1'b1);
    clear_img(); img[19] = 10'h3F0; load_board();
    run_op("row19_fill", 1'b1, 16'h000F, 0, 16, 1'b0);
    clear_img(); load_board();
    run_op("spawn_top", 1'b1, 16'h4444, 3, -2, 1'b0);

    // Reset in cycle 10 of a clear commit: rows 0 and 1 already written stay written
    clear_img(); load_board();
    @(negedge clk);
    bus.start = 1'b1; bus.commit = 1'b1; bus.matrix = 16'h4444;
    bus.pos_x = 6'd3; bus.pos_y = 6'd0;
    @(posedge clk);
    dones = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (bus.done) dones++;
      if (cyc == 10) reset = 1'b1;
    end
    @(negedge clk);
    check("rst_mid.outputs", {29'd0, bus.wr_en, bus.busy, bus.collide}, 32'd0);
    reset = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (bus.done || bus.wr_en || bus.rd_en) dones++;
    end
    check("rst_mid.no_activity", 32'(dones), 32'd0);
    check("rst_mid.board", {2'd0, ram[2], ram[1], ram[0]}, {2'd0, 10'h000, 10'h010, 10'h010});
`ifdef PLACER_FULL_ROWS_EN
    check("rst_mid.full_rows", 32'(bus.full_rows), 32'd0);
`endif

    // Randomized placements on sparse random boards
    for (int t = 0; t < 40; t++) begin
      if (t % 4 == 0) begin
        for (int i = 0; i < 32; i++)
          img[i] = ($urandom_range(0, 2) == 0) ? 10'($urandom & $urandom) : 10'd0;
        load_board();
      end
      shp = ($urandom_range(0, 9) == 0) ? 16'($urandom) : shapes[$urandom_range(0, 7)];
      run_op($sformatf("rand%0d", t), 1'($urandom), shp,
             int'($urandom_range(0, 12)) - 3, int'($urandom_range(0, 22)) - 3,
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
